// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz round controller.
package quiz_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PLAY   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int unsigned BCD_MAX_DIGITS = 8;

    function automatic logic [31:0] pow10(input int unsigned n);
        logic [31:0] p;
        p = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

    // Increment the low ndig BCD digits of v; holds at all-9s.
    function automatic logic [31:0] bcd_inc_sat(input logic [31:0] v, input int unsigned ndig);
        logic [31:0] r;
        logic        carry;
        logic        all9;
        bcd_t        d;
        r     = v;
        carry = 1'b1;
        all9  = 1'b1;
        for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < ndig) begin
                d = v[4*i +: 4];
                if (d != 4'd9) all9 = 1'b0;
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return all9 ? v : r;
    endfunction

endpackage

// File: rtl/quiz_sec_timer.sv
// Round seconds timer: prescaler, seconds load/decrement, penalty subtraction saturating at zero.
module quiz_sec_timer
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned ROUND_SEC   = 30,
    parameter int unsigned PENALTY_SEC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_run,
    input  logic       i_penalty,
    output logic [7:0] o_secs_left,
    output logic       o_zero_c
);

    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_secs;
    logic               w_tick;
    logic [8:0]         w_dec;
    logic [7:0]         w_secs_next;

    // A tick and a penalty in the same cycle both count.
    always_comb begin
        w_tick      = (r_presc == PRESC_W'(CLK_HZ - 1));
        w_dec       = 9'(w_tick) + (i_penalty ? 9'(PENALTY_SEC) : 9'd0);
        w_secs_next = (w_dec >= {1'b0, r_secs}) ? 8'd0 : 8'({1'b0, r_secs} - w_dec);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_secs  <= 8'd0;
        end else if (i_load) begin
            r_presc <= '0;
            r_secs  <= 8'(ROUND_SEC);
        end else if (i_run) begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            r_secs  <= w_secs_next;
        end
    end

    assign o_secs_left = r_secs;
    assign o_zero_c    = (r_secs == 8'd0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Decimal-to-binary quiz round controller: digit entry, timed play, BCD score and warning flash.
// Define QUIZ_HINT_EN to drive hint_mask with answer_sw ^ target while playing.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned ANS_W        = 14,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned ROUND_SEC    = 30,
    parameter int unsigned PENALTY_SEC  = 3,
    parameter int unsigned WARN_SEC     = 4,
    parameter int unsigned FLASH_ON_CYC = CLK_HZ / 10,
    parameter int unsigned SCORE_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      next_btn,
    input  logic                      go_btn,
    input  logic                      check_btn,
    input  logic [9:0]                digit_sw,
    input  logic [ANS_W-1:0]          answer_sw,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [7:0]                secs_left,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic                      playing,
    output logic                      win_show,
    output logic                      lose_show,
    output logic                      flash,
    output logic [ANS_W-1:0]          hint_mask
);

    localparam int unsigned DIG_W       = 4 * NUM_DIGITS;
    localparam int unsigned SCORE_W     = 4 * SCORE_DIGITS;
    localparam int unsigned FL_PER_SLOW = CLK_HZ / 2;
    localparam int unsigned FL_PER_FAST = CLK_HZ / 4;
    localparam int unsigned FL_W        = $clog2(FL_PER_SLOW + 1);

    state_t             r_state;
    logic               r_next_q;
    logic               r_go_q;
    logic               r_check_q;
    logic [DIG_W-1:0]   r_digits;
    logic [ANS_W-1:0]   r_target;
    logic [SCORE_W-1:0] r_score;
    logic               r_playing;
    logic               r_win;
    logic               r_lose;
    logic               r_flash;
    logic [FL_W-1:0]    r_flash_cnt;

    logic               w_next_rise;
    logic               w_go_rise;
    logic               w_check_rise;
    logic               w_digit_ok;
    bcd_t               w_digit_val;
    logic [ANS_W-1:0]   w_target_calc;
    logic               w_in_play;
    logic               w_zero;
    logic               w_correct;
    logic               w_wrong;
    logic               w_warn;
    logic [FL_W-1:0]    w_per_last;

    always_comb begin
        w_next_rise  = next_btn & ~r_next_q;
        w_go_rise    = go_btn & ~r_go_q;
        w_check_rise = check_btn & ~r_check_q;
        w_digit_ok   = $onehot(digit_sw);
        w_digit_val  = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (digit_sw[k]) w_digit_val = 4'(k);
        end
    end

    // Binary value of the entered decimal digits, truncated to the answer width.
    always_comb begin
        w_target_calc = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_target_calc = w_target_calc + ANS_W'(32'(r_digits[4*i +: 4]) * pow10(i));
        end
    end

    // An expired timer ends the round before any check is considered.
    always_comb begin
        w_in_play  = (r_state == ST_PLAY);
        w_correct  = w_in_play && !w_zero && w_check_rise && (answer_sw == r_target);
        w_wrong    = w_in_play && !w_zero && w_check_rise && (answer_sw != r_target);
        w_warn     = (secs_left != 8'd0) && (secs_left <= 8'(WARN_SEC));
        w_per_last = (secs_left <= 8'(WARN_SEC / 2)) ? FL_W'(FL_PER_FAST - 1)
                                                      : FL_W'(FL_PER_SLOW - 1);
    end

    quiz_sec_timer #(
        .CLK_HZ      (CLK_HZ),
        .ROUND_SEC   (ROUND_SEC),
        .PENALTY_SEC (PENALTY_SEC)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_load      (r_state == ST_LOAD),
        .i_run       (w_in_play && !w_correct),
        .i_penalty   (w_wrong),
        .o_secs_left (secs_left),
        .o_zero_c    (w_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ENTRY;
            r_next_q    <= 1'b0;
            r_go_q      <= 1'b0;
            r_check_q   <= 1'b0;
            r_digits    <= '0;
            r_target    <= '0;
            r_score     <= '0;
            r_playing   <= 1'b0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
            r_flash     <= 1'b0;
            r_flash_cnt <= '0;
        end else begin
            r_next_q  <= next_btn;
            r_go_q    <= go_btn;
            r_check_q <= check_btn;
            case (r_state)
                ST_ENTRY: begin
                    if (w_go_rise) begin
                        r_state <= ST_LOAD;
                    end else if (w_next_rise && w_digit_ok) begin
                        r_digits <= (r_digits << 4) | DIG_W'(w_digit_val);
                    end
                end
                ST_LOAD: begin
                    r_target    <= w_target_calc;
                    r_state     <= ST_PLAY;
                    r_playing   <= 1'b1;
                    r_flash     <= 1'b0;
                    r_flash_cnt <= '0;
                end
                ST_PLAY: begin
                    if (w_zero) begin
                        r_state   <= ST_RESULT;
                        r_lose    <= 1'b1;
                        r_playing <= 1'b0;
                        r_flash   <= 1'b0;
                    end else if (w_correct) begin
                        r_state   <= ST_RESULT;
                        r_win     <= 1'b1;
                        r_score   <= SCORE_W'(bcd_inc_sat(32'(r_score), SCORE_DIGITS));
                        r_playing <= 1'b0;
                        r_flash   <= 1'b0;
                    end else begin
                        if (w_wrong || (r_flash_cnt >= w_per_last)) begin
                            r_flash_cnt <= '0;
                        end else begin
                            r_flash_cnt <= r_flash_cnt + FL_W'(1);
                        end
                        r_flash <= w_warn && (32'(r_flash_cnt) < FLASH_ON_CYC);
                    end
                end
                ST_RESULT: begin
                    if (w_go_rise) begin
                        r_state  <= ST_ENTRY;
                        r_digits <= '0;
                        r_win    <= 1'b0;
                        r_lose   <= 1'b0;
                    end
                end
                default: r_state <= ST_ENTRY;
            endcase
        end
    end

`ifdef QUIZ_HINT_EN
    logic [ANS_W-1:0] r_hint;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hint <= '0;
        end else begin
            r_hint <= w_in_play ? (answer_sw ^ r_target) : '0;
        end
    end

    assign hint_mask = r_hint;
`else
    assign hint_mask = '0;
`endif

    assign digits    = r_digits;
    assign score_bcd = r_score;
    assign playing   = r_playing;
    assign win_show  = r_win;
    assign lose_show = r_lose;
    assign flash     = r_flash;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed self-checking bench for quiz_round_ctrl with a 100-cycle second.
module tb_quiz_round_ctrl;
    import quiz_pkg::*;

    logic        clk;
    logic        reset;
    logic        next_btn;
    logic        go_btn;
    logic        check_btn;
    logic [9:0]  digit_sw;
    logic [13:0] answer_sw;
    logic [15:0] digits;
    logic [7:0]  secs_left;
    logic [7:0]  score_bcd;
    logic        playing;
    logic        win_show;
    logic        lose_show;
    logic        flash;
    logic [13:0] hint_mask;

    int checks;
    int failures;

    quiz_round_ctrl #(
        .NUM_DIGITS   (4),
        .ANS_W        (14),
        .CLK_HZ       (100),
        .ROUND_SEC    (10),
        .PENALTY_SEC  (3),
        .WARN_SEC     (4),
        .FLASH_ON_CYC (5),
        .SCORE_DIGITS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .next_btn  (next_btn),
        .go_btn    (go_btn),
        .check_btn (check_btn),
        .digit_sw  (digit_sw),
        .answer_sw (answer_sw),
        .digits    (digits),
        .secs_left (secs_left),
        .score_bcd (score_bcd),
        .playing   (playing),
        .win_show  (win_show),
        .lose_show (lose_show),
        .flash     (flash),
        .hint_mask (hint_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enter_digit(input int d);
        digit_sw = 10'(1 << d);
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
        tick();
    endtask

    // Leaves the DUT sampled just after the LOAD->PLAY edge.
    task automatic start_round();
        go_btn = 1'b1;
        tick();
        go_btn = 1'b0;
        tick();
    endtask

    task automatic press_go();
        go_btn = 1'b1;
        tick();
        go_btn = 1'b0;
        tick();
    endtask

    int          lose_c;
    int          hi_slow;
    int          hi_fast;
    int          hi_other;
    int          rise_slow;
    int          rise_fast;
    int          bad_int;
    int          last_slow;
    int          last_fast;
    int          waited;
    logic        prev_fl;
    logic [31:0] hint_exp;

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        next_btn  = 1'b0;
        go_btn    = 1'b0;
        check_btn = 1'b0;
        digit_sw  = 10'd0;
        answer_sw = 14'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits",  32'(digits),    32'h0);
        chk("rst_secs",    32'(secs_left), 32'd0);
        chk("rst_score",   32'(score_bcd), 32'h0);
        chk("rst_playing", 32'(playing),   32'd0);
        chk("rst_flags",   32'({win_show, lose_show, flash}), 32'd0);
        chk("rst_hint",    32'(hint_mask), 32'd0);
        reset = 1'b0;
        tick();

        // Round 1: enter 1234 and answer correctly
        enter_digit(1);
        chk("dig_1", 32'(digits), 32'h1);
        enter_digit(2);
        enter_digit(3);
        enter_digit(4);
        chk("dig_1234", 32'(digits), 32'h1234);
        digit_sw = 10'b0000000011;
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
        tick();
        chk("dig_multihot", 32'(digits), 32'h1234);
        go_btn = 1'b1;
        tick();
        chk("load_not_playing", 32'(playing), 32'd0);
        go_btn = 1'b0;
        tick();
        chk("target_1234", 32'(dut.r_target), 32'd1234);
        chk("play_playing", 32'(playing), 32'd1);
        chk("play_secs10", 32'(secs_left), 32'd10);
        answer_sw = 14'h0F0;
        tick();
        tick();
`ifdef QUIZ_HINT_EN
        hint_exp = 32'h422;
`else
        hint_exp = 32'h0;
`endif
        chk("hint", 32'(hint_mask), hint_exp);
        answer_sw = 14'd1234;
        check_btn = 1'b1;
        tick();
        check_btn = 1'b0;
        chk("win_show", 32'(win_show), 32'd1);
        chk("win_lose_low", 32'(lose_show), 32'd0);
        chk("score_01", 32'(score_bcd), 32'h01);
        chk("win_not_playing", 32'(playing), 32'd0);
        repeat (3) tick();
        chk("result_secs_frozen", 32'(secs_left), 32'd10);
        press_go();
        chk("entry_digits_clr", 32'(digits), 32'h0);
        chk("entry_win_clr", 32'(win_show), 32'd0);
        chk("target_kept", 32'(dut.r_target), 32'd1234);

        // Round 2: held button, invalid digits, penalties to zero
        digit_sw = 10'(1 << 5);
        next_btn = 1'b1;
        repeat (20) tick();
        next_btn = 1'b0;
        tick();
        chk("hold_one_shift", 32'(digits), 32'h5);
        digit_sw = 10'd0;
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
        tick();
        chk("dig_zero_sw", 32'(digits), 32'h5);
        enter_digit(7);
        chk("dig_57", 32'(digits), 32'h57);
        start_round();
        chk("target_57", 32'(dut.r_target), 32'd57);
        answer_sw = 14'd0;
        check_btn = 1'b1;
        tick();
        check_btn = 1'b0;
        chk("penalty_secs7", 32'(secs_left), 32'd7);
        chk("penalty_still_play", 32'(playing), 32'd1);
        waited = 0;
        while (secs_left != 8'd2 && waited < 2000) begin
            tick();
            waited++;
        end
        chk("reach_secs2", 32'(secs_left), 32'd2);
        check_btn = 1'b1;
        tick();
        check_btn = 1'b0;
        chk("penalty_sat0", 32'(secs_left), 32'd0);
        chk("lose_not_yet", 32'(lose_show), 32'd0);
        tick();
        chk("lose_show", 32'(lose_show), 32'd1);
        chk("lose_win_low", 32'(win_show), 32'd0);
        chk("lose_score_kept", 32'(score_bcd), 32'h01);
        press_go();

        // Round 3: timeout with flash cadence, go ignored mid-play
        enter_digit(9);
        enter_digit(9);
        start_round();
        lose_c    = -1;
        hi_slow   = 0;
        hi_fast   = 0;
        hi_other  = 0;
        rise_slow = 0;
        rise_fast = 0;
        bad_int   = 0;
        last_slow = -1;
        last_fast = -1;
        prev_fl   = 1'b0;
        for (int c = 1; c <= 1200 && lose_c < 0; c++) begin
            go_btn = (c == 300);
            tick();
            if (lose_show) lose_c = c;
            if (flash) begin
                if (secs_left >= 8'd3 && secs_left <= 8'd4) begin
                    hi_slow++;
                    if (!prev_fl) begin
                        rise_slow++;
                        if (last_slow >= 0 && (c - last_slow) != 50) bad_int++;
                        last_slow = c;
                    end
                end else if (secs_left >= 8'd1 && secs_left <= 8'd2) begin
                    hi_fast++;
                    if (!prev_fl) begin
                        rise_fast++;
                        if (last_fast >= 0 && (c - last_fast) != 25) bad_int++;
                        last_fast = c;
                    end
                end else begin
                    hi_other++;
                end
            end
            prev_fl = flash;
        end
        go_btn = 1'b0;
        chk("timeout_cycle", 32'(lose_c), 32'd1001);
        chk("timeout_secs0", 32'(secs_left), 32'd0);
        chk("flash_hi_slow", 32'(hi_slow), 32'd20);
        chk("flash_hi_fast", 32'(hi_fast), 32'd40);
        chk("flash_hi_other", 32'(hi_other), 32'd0);
        chk("flash_rise_slow", 32'(rise_slow), 32'd4);
        chk("flash_rise_fast", 32'(rise_fast), 32'd8);
        chk("flash_period", 32'(bad_int), 32'd0);
        chk("timeout_flash_off", 32'(flash), 32'd0);
        chk("timeout_score", 32'(score_bcd), 32'h01);
        press_go();

        // Round 4: asynchronous reset in the middle of play
        start_round();
        repeat (5) tick();
        chk("pre_rst_playing", 32'(playing), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(dut.r_state), 32'(ST_ENTRY));
        chk("arst_playing", 32'(playing), 32'd0);
        chk("arst_secs", 32'(secs_left), 32'd0);
        chk("arst_score", 32'(score_bcd), 32'h0);
        chk("arst_digits", 32'(digits), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
